// File: rtl/uart_pkt_rx_if.sv
// Byte-stream bundle around the packet deframer.
// Signal names are from the deframer's side: i_* flow in, o_* flow out.
interface uart_pkt_rx_if;
  logic       i_vld;
  logic [7:0] i_data;
  logic       i_pc_pass;
  logic       o_rdy;
  logic       o_vld;
  logic [7:0] o_data;
  logic       o_sop;
  logic       o_eop;
  logic       i_rdy;

  modport slave (
    input  i_vld, i_data, i_pc_pass, i_rdy,
    output o_rdy, o_vld, o_data, o_sop, o_eop
  );

  modport master (
    output i_vld, i_data, i_pc_pass, i_rdy,
    input  o_rdy, o_vld, o_data, o_sop, o_eop
  );
endinterface

// File: rtl/uart_pkt_rx.sv
// Header/len/payload/checksum deframer; releases payload after checksum.
// Optional inter-byte timeout: define UART_PKT_TIMEOUT_EN.
module uart_pkt_rx #(
  parameter logic [7:0]  HEADER0     = 8'h55,
  parameter logic [7:0]  HEADER1     = 8'hAA,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic         clk,
  input  logic         rst,
  uart_pkt_rx_if.slave bus,
  output logic         o_err,
  output logic [1:0]   o_err_code,
  output logic [15:0]  o_pkt_cnt
);
  localparam int unsigned AW =
    (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAXL = 8'(MAX_LEN);

  localparam logic [1:0] E_TMO  = 2'b00;
  localparam logic [1:0] E_PAR  = 2'b01;
  localparam logic [1:0] E_LEN  = 2'b10;
  localparam logic [1:0] E_CSUM = 2'b11;

  typedef enum logic [2:0] {
    HUNT0, HUNT1, LEN, PAYLOAD, CSUM, OUT
  } state_e;

  state_e      state_q;
  logic [7:0]  len_q;
  logic [7:0]  idx_q;
  logic [7:0]  csum_q;
  logic        o_rdy_q;
  logic        o_vld_q;
  logic [7:0]  o_data_q;
  logic        o_sop_q;
  logic        o_eop_q;
  logic        o_err_q;
  logic [1:0]  o_err_code_q;
  logic [15:0] pkt_cnt_q;
  logic [7:0]  buf_q [2**AW];

  logic       acc;
  logic       out_xfer;
  logic       active;
  logic       par_bad;
  logic       wr_en;
  logic       tmo_hit;
  logic [7:0] csum_add;

  assign acc      = bus.i_vld & o_rdy_q;
  assign out_xfer = o_vld_q & bus.i_rdy;
  assign active   = state_q inside {HUNT1, LEN, PAYLOAD, CSUM};
  assign par_bad  = acc & ~bus.i_pc_pass & active;
  assign wr_en    = acc & bus.i_pc_pass
                  & (state_q == PAYLOAD);
  assign csum_add = csum_q + bus.i_data;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = active & ~acc
                 & (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (!active || acc || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  // Payload store has no reset; only the index is cleared on errors.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[idx_q[AW-1:0]] <= bus.i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT0;
      len_q        <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      o_rdy_q      <= 1'b0;
      o_vld_q      <= 1'b0;
      o_data_q     <= '0;
      o_sop_q      <= 1'b0;
      o_eop_q      <= 1'b0;
      o_err_q      <= 1'b0;
      o_err_code_q <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      o_err_q <= 1'b0;
      o_rdy_q <= 1'b1;
      if (tmo_hit) begin
        o_err_q      <= 1'b1;
        o_err_code_q <= E_TMO;
        state_q      <= HUNT0;
        idx_q        <= '0;
      end else if (par_bad) begin
        o_err_q      <= 1'b1;
        o_err_code_q <= E_PAR;
        state_q      <= HUNT0;
        idx_q        <= '0;
      end else begin
        unique case (state_q)
          HUNT0: begin
            if (acc && bus.i_pc_pass &&
                bus.i_data == HEADER0) begin
              state_q <= HUNT1;
            end
          end
          HUNT1: begin
            if (acc) begin
              if (bus.i_data == HEADER1) begin
                state_q <= LEN;
              end else if (bus.i_data != HEADER0) begin
                state_q <= HUNT0;
              end
            end
          end
          LEN: begin
            if (acc) begin
              if (bus.i_data == 8'd0 ||
                  bus.i_data > MAXL) begin
                o_err_q      <= 1'b1;
                o_err_code_q <= E_LEN;
                state_q      <= HUNT0;
              end else begin
                len_q   <= bus.i_data;
                csum_q  <= bus.i_data;
                idx_q   <= '0;
                state_q <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (acc) begin
              csum_q <= csum_add;
              idx_q  <= idx_q + 8'd1;
              if (idx_q == len_q - 8'd1) begin
                state_q <= CSUM;
              end
            end
          end
          CSUM: begin
            if (acc) begin
              if (csum_add == 8'd0) begin
                state_q  <= OUT;
                o_rdy_q  <= 1'b0;
                o_vld_q  <= 1'b1;
                o_data_q <= buf_q[0];
                o_sop_q  <= 1'b1;
                o_eop_q  <= (len_q == 8'd1);
                idx_q    <= 8'd1;
              end else begin
                o_err_q      <= 1'b1;
                o_err_code_q <= E_CSUM;
                state_q      <= HUNT0;
                idx_q        <= '0;
              end
            end
          end
          OUT: begin
            o_rdy_q <= 1'b0;
            if (out_xfer) begin
              if (o_eop_q) begin
                o_vld_q   <= 1'b0;
                o_sop_q   <= 1'b0;
                o_eop_q   <= 1'b0;
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
                idx_q     <= '0;
                o_rdy_q   <= 1'b1;
                state_q   <= HUNT0;
              end else begin
                o_data_q <= buf_q[idx_q[AW-1:0]];
                o_sop_q  <= 1'b0;
                o_eop_q  <= (idx_q == len_q - 8'd1);
                idx_q    <= idx_q + 8'd1;
              end
            end
          end
          default: state_q <= HUNT0;
        endcase
      end
    end
  end

  assign bus.o_rdy  = o_rdy_q;
  assign bus.o_vld  = o_vld_q;
  assign bus.o_data = o_data_q;
  assign bus.o_sop  = o_sop_q;
  assign bus.o_eop  = o_eop_q;
  assign o_err      = o_err_q;
  assign o_err_code = o_err_code_q;
  assign o_pkt_cnt  = pkt_cnt_q;
endmodule

// File: tb/tb_uart_pkt_rx.sv
// Scoreboard bench for uart_pkt_rx: random packets vs a packet-level model.
// Timeout scenario runs only when UART_PKT_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_uart_pkt_rx;
  localparam int MAXL = 16;
`ifdef UART_PKT_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 20000;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic [15:0] o_pkt_cnt;

  uart_pkt_rx_if bus();

  uart_pkt_rx #(
    .MAX_LEN(MAXL),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .o_err(o_err),
    .o_err_code(o_err_code),
    .o_pkt_cnt(o_pkt_cnt)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   err_q[$];
  int   exp_cnt  = 0;
  bit   mon_en   = 1'b0;
  int   rdy_mode = 1;
  logic [7:0] pk[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sink ready: 0 random, 1 high, 2 low, 3 pattern 1,0,0,...
  initial begin
    int ph = 0;
    bus.i_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.i_rdy = ($urandom_range(0, 2) != 0);
        1: bus.i_rdy = 1'b1;
        3: bus.i_rdy = (ph % 3 == 0);
        default: bus.i_rdy = 1'b0;
      endcase
      ph++;
    end
  end

  // Monitor: pops expectations whenever the DUT presents output.
  initial begin
    bit         hold = 1'b0;
    bit         cnt_chk = 1'b0;
    logic [9:0] prev = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hold = 1'b0;
        cnt_chk = 1'b0;
        continue;
      end
      if (cnt_chk) begin
        chk("pkt_cnt", o_pkt_cnt, exp_cnt & 16'hFFFF);
        cnt_chk = 1'b0;
      end
      if (hold) begin
        chk("hold_vld", bus.o_vld, 1);
        chk("hold_bus", {bus.o_data, bus.o_sop, bus.o_eop}, prev);
      end
      hold = 1'b0;
      if (bus.o_vld) begin
        chk("rdy_in_out", bus.o_rdy, 0);
        if (bus.i_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", bus.o_vld, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", bus.o_data, e.d);
            chk("out_sop", bus.o_sop, e.sop);
            chk("out_eop", bus.o_eop, e.eop);
            if (e.eop) begin
              exp_cnt++;
              cnt_chk = 1'b1;
            end
          end
        end else begin
          hold = 1'b1;
          prev = {bus.o_data, bus.o_sop, bus.o_eop};
        end
      end
      if (o_err) begin
        if (err_q.size() == 0) begin
          chk("unexpected_err", o_err, 0);
        end else begin
          chk("err_code", o_err_code, err_q.pop_front());
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b, input bit p);
    int t = 0;
    bus.i_vld     = 1'b1;
    bus.i_data    = b;
    bus.i_pc_pass = p;
    while (!bus.o_rdy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("send_timeout", bus.o_rdy, 1);
    @(negedge clk);
    bus.i_vld = 1'b0;
  endtask

  task automatic mk_good(input int len);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'(len);
    pk.delete();
    pk.push_back(8'h55);
    pk.push_back(8'hAA);
    pk.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      s = s + b;
      pk.push_back(b);
    end
    pk.push_back(8'(0) - s);
  endtask

  // Model: decide the packet's fate from its bytes, then send it.
  task automatic drive_pkt(input int ppos);
    int         len;
    int         last;
    int         code;
    logic [7:0] s;
    len  = int'(pk[2]);
    code = -1;
    s    = 8'd0;
    if (ppos > 0) begin
      last = ppos;
      code = 1;
    end else if (len == 0 || len > MAXL) begin
      last = 2;
      code = 2;
    end else begin
      last = len + 3;
      for (int i = 2; i <= last; i++) s = s + pk[i];
      if (s != 8'd0) begin
        code = 3;
      end else begin
        for (int i = 0; i < len; i++)
          exp_q.push_back(exp_t'{pk[3+i], i == 0, i == len - 1});
      end
    end
    if (code >= 0) err_q.push_back(code);
    for (int i = 0; i <= last; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      send(pk[i], i != ppos || ppos == 0);
    end
    if (code >= 0) chk("err_timing", o_err, 1);
    else chk("vld_latency", bus.o_vld, 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() + err_q.size()) != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size() + err_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nb;
    int         k;
    int         ln;
    bus.i_vld     = 1'b0;
    bus.i_data    = 8'h00;
    bus.i_pc_pass = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy", bus.o_rdy, 0);
    chk("rst_out", {bus.o_vld, bus.o_data, bus.o_sop, bus.o_eop}, 0);
    chk("rst_err", {o_err, o_err_code}, 0);
    chk("rst_cnt", o_pkt_cnt, 0);
    rst = 1'b1;
    chk("rdy_release", bus.o_rdy, 0);
    @(negedge clk);
    chk("rdy_after", bus.o_rdy, 1);
    mon_en = 1'b1;

    pk = {8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    drive_pkt(0);
    wait_drain();
    rdy_mode = 0;
    pk = {8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h00};
    drive_pkt(0);
    mk_good(2);
    drive_pkt(0);
    pk = {8'h55, 8'hAA, 8'h00};
    drive_pkt(0);
    send(8'h55, 1'b1);
    pk = {8'h55, 8'hAA, 8'h01, 8'h5A, 8'hA5};
    drive_pkt(0);
    wait_drain();
    rdy_mode = 3;
    mk_good(4);
    drive_pkt(0);
    wait_drain();
    rdy_mode = 0;
    mk_good(5);
    drive_pkt(4);
    mk_good(MAXL);
    drive_pkt(0);
    mk_good(1);
    pk[2] = 8'(MAXL + 1);
    drive_pkt(0);
    wait_drain();

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        do nb = 8'($urandom); while (nb == 8'h55);
        send(nb, 1'($urandom));
      end
      k  = $urandom_range(0, 5);
      ln = $urandom_range(1, MAXL);
      mk_good(ln);
      if (k == 3) pk[ln+3] = pk[ln+3] ^ 8'($urandom_range(1, 255));
      if (k == 4) begin
        if ($urandom_range(0, 1) == 0) pk[2] = 8'h00;
        else pk[2] = 8'($urandom_range(MAXL + 1, 255));
      end
      drive_pkt(k == 5 ? $urandom_range(1, ln + 3) : 0);
    end
    wait_drain();

    mon_en   = 1'b0;
    rdy_mode = 2;
    mk_good(3);
    for (int i = 0; i < pk.size(); i++) send(pk[i], 1'b1);
    chk("mid_out_vld", bus.o_vld, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out",
        {bus.o_vld, bus.o_data, bus.o_sop, bus.o_eop, bus.o_rdy}, 0);
    chk("mid_rst_err", {o_err, o_err_code}, 0);
    chk("mid_rst_cnt", o_pkt_cnt, 0);
    @(negedge clk);
    rst      = 1'b1;
    exp_cnt  = 0;
    rdy_mode = 0;
    @(negedge clk);
    mon_en = 1'b1;
    mk_good(2);
    drive_pkt(0);
    wait_drain();

`ifdef UART_PKT_TIMEOUT_EN
    err_q.push_back(0);
    send(8'h55, 1'b1);
    send(8'hAA, 1'b1);
    send(8'h04, 1'b1);
    send(8'h01, 1'b1);
    repeat (TMO + 5) @(negedge clk);
    wait_drain();
    mk_good(3);
    drive_pkt(0);
    wait_drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_pkt_rx.md
Name: uart_pkt_rx

Overview:
- Packet deframer directly downstream of uart_rx; consumes its byte stream (o_vld/o_data/pc_pass) and drives its i_rdy.
- Hunts a two-byte header, reads a length byte, payload and checksum, and buffers the payload internally.
- Releases the payload as a sop/eop-framed byte stream only after the checksum verifies; flags bad packets on an error pulse.

Parameters:
HEADER0, 8'h55, first sync byte
HEADER1, 8'hAA, second sync byte
MAX_LEN, 16, maximum payload bytes (1..255); sizes the internal buffer
TIMEOUT_CYC, 20000, inter-byte timeout in clk cycles (used only with UART_PKT_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is asynchronous and active-low (rst=0 resets)
i_vld  input  1  byte valid from uart_rx
i_data  input  8  received byte
i_pc_pass  input  1  parity pass flag, qualified by i_vld
o_rdy  output  1  ready to uart_rx (its i_rdy)
o_vld  output  1  payload byte valid
o_data  output  8  payload byte
o_sop  output  1  first payload byte of packet, qualified by o_vld
o_eop  output  1  last payload byte of packet, qualified by o_vld
i_rdy  input  1  downstream ready
o_err  output  1  one-cycle error pulse
o_err_code  output  2  00 timeout, 01 parity, 10 bad length, 11 checksum; valid with o_err
o_pkt_cnt  output  16  count of good packets delivered

Behaviour:
- Reset values: o_rdy=0, o_vld=0, o_data=0, o_sop=0, o_eop=0, o_err=0, o_err_code=0, o_pkt_cnt=0, FSM=HUNT0. o_rdy rises the first cycle after reset release.
- Input transfer on i_vld&&o_rdy. Output transfer on o_vld&&i_rdy.
- States:
  - HUNT0: byte==HEADER0 -> HUNT1; else stay.
  - HUNT1: byte==HEADER1 -> LEN; byte==HEADER0 -> stay; else -> HUNT0.
  - LEN: 1..MAX_LEN -> latch len, csum=len -> PAYLOAD; 0 or >MAX_LEN -> err code 10 -> HUNT0.
  - PAYLOAD: write buf[idx], csum+=byte (mod 256), idx++; after len bytes -> CSUM.
  - CSUM: (csum+byte) mod 256 == 0 -> OUT; else err code 11 -> HUNT0.
  - OUT: o_rdy=0; o_vld=1 from the cycle after the checksum byte is accepted; bytes buf[0..len-1] in order; o_data/o_sop/o_eop held stable while i_rdy=0. After the eop transfer: o_pkt_cnt++ (wraps at 16'hFFFF->0) -> HUNT0, o_rdy=1 next cycle.
- Parity: any accepted byte with i_pc_pass=0 in HUNT1/LEN/PAYLOAD/CSUM -> err code 01 -> HUNT0, byte discarded. In HUNT0 it is discarded silently.
- o_rdy=1 in every state except OUT.
- Error pulse: o_err high exactly one cycle, on the cycle after the offending byte is accepted. The buffer is not cleared, only the index is reset.
- len=1: the single output byte has o_sop=o_eop=1.
- Reset mid-operation (any state, including OUT with o_vld=1) returns to reset values immediately. The partial packet is dropped and not counted.

Optional Feature:
UART_PKT_TIMEOUT_EN
- Defined:
  - A counter runs while FSM is in HUNT1/LEN/PAYLOAD/CSUM; it clears on every accepted byte.
  - Reaching TIMEOUT_CYC -> o_err=1, code 00, FSM -> HUNT0.
  - The counter is frozen and cleared in HUNT0 and OUT.
- Not defined: no counter logic is generated; a stalled packet waits indefinitely; code 00 is never emitted.

Test Plan:
- Good packet: feed 55 AA 03 11 22 33 97 (checksum 97 = -(03+11+22+33)), i_rdy=1 -> o_data 11,22,33 on consecutive cycles starting the cycle after 97 is accepted; sop on 11, eop on 33; o_pkt_cnt=1; o_err never high.
- Checksum error: 55 AA 02 01 02 00 -> no o_vld; o_err=1 with code 11 for one cycle; a following good packet is delivered normally.
- Length and resync: 55 AA 00 -> err code 10. 55 55 AA 01 5A A5 -> payload 5A delivered with sop=eop=1.
- Backpressure: good 4-byte packet with i_rdy toggling 1,0,0,1,... -> o_data/o_sop/o_eop stable while i_rdy=0; o_rdy=0 throughout OUT; all 4 bytes delivered in order.
- Parity fail: i_pc_pass=0 on the second payload byte -> err code 01; no output; o_pkt_cnt unchanged.
- Reset mid-OUT: drive rst=0 while o_vld=1 -> all outputs 0 immediately; o_pkt_cnt=0. With UART_PKT_TIMEOUT_EN and TIMEOUT_CYC=100: send 55 AA 04 01 then idle 100 cycles -> err code 00; FSM back in HUNT0.
